frame_buffer_pingpong: RTL and testbench
========================================

Name: frame_buffer_pingpong

Overview:
- Single-clock, parametrised, double-buffered (ping-pong) frame store between the camera capture path and the VGA read path.
- The writer fills the back bank while the reader scans the front bank.
- Banks swap only at a read frame boundary, and only after a complete write frame exists, so the display never tears.
- A writer FSM discards partial frames and counts dropped frames.

Parameters:
- H_RES, 320, pixels per line.
- V_RES, 240, lines per frame.
- DATA_W, 16, pixel width (RGB565 default).
- DEPTH, H_RES*V_RES, words per bank (derived, not overridden).
- ADDR_W, $clog2(DEPTH), address width (17 at defaults).
- DROP_W, 8, width of the dropped-frame counter.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- we  in  1  write strobe for the current pixel.
- wAddr  in  ADDR_W  write pixel address (y*H_RES+x).
- wData  in  DATA_W  write pixel.
- wFrameEnd  in  1  one-cycle pulse: last pixel of the write frame (may coincide with the last we).
- rFrameStart  in  1  one-cycle pulse from the VGA timing at start of the read frame (vsync).
- oe  in  1  read enable.
- rAddr  in  ADDR_W  read pixel address.
- rData  out  DATA_W  read pixel, registered.
- rValid  out  1  rData holds the result of an oe issued the previous cycle.
- frameReady  out  1  a completed frame is pending swap.
- wSkip  out  1  writes are currently being discarded (FSM in W_HOLD or W_SKIP).
- dropCount  out  DROP_W  saturating count of discarded write frames.
- rBank  out  1  index of the front bank.

Behaviour:
- Reset (synchronous, clk edge with reset=1) sets:
  - state=W_FILL, wBank=0, rBank=1, frameReady=0, rData=0, rValid=0, dropCount=0.
  - Memory contents are not reset.
  - Reset mid-frame abandons any pending frame. The first post-reset writes go to bank 0.
- Write path:
  - A write commits to mem[wBank][wAddr] on the clk edge, only when we=1, state=W_FILL and wAddr<DEPTH.
  - Out-of-range wAddr is silently ignored.
- Read path:
  - Latency is 1 cycle. On oe=1, rData<=mem[rBank][rAddr] and rValid<=1. rAddr>=DEPTH returns 0.
  - On oe=0, rData holds its value and rValid<=0.
- Swap:
  - Occurs on a rFrameStart cycle when frameReady=1, or when wFrameEnd is also present in W_FILL.
  - Effect: rBank<=wBank, wBank<=rBank, frameReady<=0.
  - The swap takes effect the next cycle. A read issued on the rFrameStart cycle uses the old rBank.
  - rFrameStart with no pending frame leaves the banks unchanged; the reader repeats the old frame.
- Writer FSM (wSkip = state!=W_FILL):
  - W_FILL:
    - wFrameEnd with rFrameStart: swap, stay W_FILL.
    - wFrameEnd alone: frameReady<=1, go W_HOLD.
  - W_HOLD (back bank full, writes discarded):
    - wFrameEnd without rFrameStart: dropCount+1, stay W_HOLD.
    - rFrameStart without wFrameEnd: swap, go W_SKIP.
    - rFrameStart with wFrameEnd: swap, dropCount+1, go W_FILL.
  - W_SKIP (new back bank but writer is mid-frame, writes discarded):
    - wFrameEnd: dropCount+1, go W_FILL.
    - rFrameStart is ignored.
- The last-pixel write on a wFrameEnd cycle in W_FILL commits before the state change.
- dropCount saturates at 2^DROP_W-1 and never wraps.
- Read and write always target different banks, so there is no read/write collision.

Decomposition:
- Package fb_pkg holds:
  - typedef enum logic [1:0] {W_FILL, W_HOLD, W_SKIP} wr_state_t;
  - default H_RES/V_RES/DATA_W constants;
  - a function fb_depth(h,v).
- Sub-module fb_bank: simple dual-port RAM, one write port plus one registered read port with enable, parametrised by DATA_W/DEPTH; instantiated twice.
- The top level holds the FSM, bank pointers, address range checks, read mux and counter.
- rData is taken from the selected bank's registered output. Bank selection is registered alongside it so the mux matches the 1-cycle latency.

Test Plan:
- Reset, then read bank 1: reset=1 for 2 cycles, then oe=1 with rAddr=0. Required: rBank=1, rValid=1 one cycle later, frameReady=0, dropCount=0, wSkip=0.
- Fill and swap:
  - Stimulus: write a frame of wData=wAddr[15:0] with wFrameEnd on addr 76799, then rFrameStart.
  - Required after wFrameEnd: frameReady=1, wSkip=1.
  - Required one cycle after rFrameStart: rBank=0; reading addr 1234 gives rData=1234 one cycle later.
- Simultaneous end/start: wFrameEnd and rFrameStart on the same cycle in W_FILL. Required: swap next cycle, state stays W_FILL, wSkip=0, frameReady=0.
- Drop while held: two wFrameEnd without rFrameStart, then writes of 0xFFFF, then rFrameStart. Required: dropCount=1; front data unchanged (no 0xFFFF); state W_SKIP after the swap; next wFrameEnd gives dropCount=2 and wSkip=0.
- Range/saturation:
  - we with wAddr=76800 leaves memory unchanged.
  - oe with rAddr=76800 gives rData=0.
  - 300 drops give dropCount=255.
  - Reset asserted mid-W_HOLD gives frameReady=0 and rBank=1.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the ping-pong frame buffer.
package fb_pkg;

  localparam int unsigned H_RES_DEF  = 320;
  localparam int unsigned V_RES_DEF  = 240;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned DROP_W_DEF = 8;

  typedef enum logic [1:0] {
    W_FILL = 2'd0,
    W_HOLD = 2'd1,
    W_SKIP = 2'd2
  } wr_state_t;

  function automatic int unsigned fb_depth(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

endpackage

// File: rtl/fb_bank.sv
// One frame bank: simple dual-port RAM, one write port, one registered read port with enable.
module fb_bank
  import fb_pkg::*;
#(
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DEPTH  = fb_depth(H_RES_DEF, V_RES_DEF),
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read register holds its value while re is low.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: writer fills the back bank, reader scans the front bank,
// banks swap only on a read frame start once a complete write frame is pending.
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter  int unsigned H_RES  = H_RES_DEF,
  parameter  int unsigned V_RES  = V_RES_DEF,
  parameter  int unsigned DATA_W = DATA_W_DEF,
  parameter  int unsigned DROP_W = DROP_W_DEF,
  localparam int unsigned DEPTH  = fb_depth(H_RES, V_RES),
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wAddr,
  input  logic [DATA_W-1:0] wData,
  input  logic              wFrameEnd,
  input  logic              rFrameStart,
  input  logic              oe,
  input  logic [ADDR_W-1:0] rAddr,
  output logic [DATA_W-1:0] rData,
  output logic              rValid,
  output logic              frameReady,
  output logic              wSkip,
  output logic [DROP_W-1:0] dropCount,
  output logic              rBank
);

  localparam logic [ADDR_W:0]   DEPTH_CMP = (ADDR_W+1)'(DEPTH);
  localparam logic [DROP_W-1:0] DROP_MAX  = '1;

  wr_state_t         state_d, state_q;
  logic              wbank_d, wbank_q;
  logic              rbank_d, rbank_q;
  logic              ready_d, ready_q;
  logic              wskip_d, wskip_q;
  logic [DROP_W-1:0] drop_d, drop_q;
  logic              rvalid_d, rvalid_q;
  logic              rsel_d, rsel_q;
  logic              rzero_d, rzero_q;

  logic              swap;
  logic              drop_inc;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_ok;
  logic [DATA_W-1:0] rd0, rd1;

  assign wr_in_range = {1'b0, wAddr} < DEPTH_CMP;
  assign rd_in_range = {1'b0, rAddr} < DEPTH_CMP;
  assign wr_ok       = we && (state_q == W_FILL) && wr_in_range;

  fb_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank0 (
    .clk   (clk),
    .we    (wr_ok && !wbank_q),
    .waddr (wAddr),
    .wdata (wData),
    .re    (oe && rd_in_range && !rbank_q),
    .raddr (rAddr),
    .rdata (rd0)
  );

  fb_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_bank1 (
    .clk   (clk),
    .we    (wr_ok && wbank_q),
    .waddr (wAddr),
    .wdata (wData),
    .re    (oe && rd_in_range && rbank_q),
    .raddr (rAddr),
    .rdata (rd1)
  );

  // Writer FSM, bank pointers and drop counter.
  always_comb begin
    state_d  = state_q;
    wbank_d  = wbank_q;
    rbank_d  = rbank_q;
    ready_d  = ready_q;
    drop_d   = drop_q;
    swap     = 1'b0;
    drop_inc = 1'b0;

    case (state_q)
      W_FILL: begin
        if (wFrameEnd) begin
          if (rFrameStart) begin
            swap = 1'b1;
          end else begin
            ready_d = 1'b1;
            state_d = W_HOLD;
          end
        end
      end
      W_HOLD: begin
        if (rFrameStart) begin
          swap = 1'b1;
          if (wFrameEnd) begin
            drop_inc = 1'b1;
            state_d  = W_FILL;
          end else begin
            state_d  = W_SKIP;
          end
        end else if (wFrameEnd) begin
          drop_inc = 1'b1;
        end
      end
      W_SKIP: begin
        if (wFrameEnd) begin
          drop_inc = 1'b1;
          state_d  = W_FILL;
        end
      end
      default: state_d = W_FILL;
    endcase

    if (swap) begin
      rbank_d = wbank_q;
      wbank_d = rbank_q;
      ready_d = 1'b0;
    end
    if (drop_inc && (drop_q != DROP_MAX)) begin
      drop_d = drop_q + DROP_W'(1);
    end
  end

  assign wskip_d = (state_d != W_FILL);

  // Bank select and out-of-range flag track the registered read data.
  always_comb begin
    rvalid_d = oe;
    rsel_d   = rsel_q;
    rzero_d  = rzero_q;
    if (oe) begin
      rsel_d  = rbank_q;
      rzero_d = !rd_in_range;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= W_FILL;
      wbank_q  <= 1'b0;
      rbank_q  <= 1'b1;
      ready_q  <= 1'b0;
      wskip_q  <= 1'b0;
      drop_q   <= '0;
      rvalid_q <= 1'b0;
      rsel_q   <= 1'b0;
      rzero_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      wbank_q  <= wbank_d;
      rbank_q  <= rbank_d;
      ready_q  <= ready_d;
      wskip_q  <= wskip_d;
      drop_q   <= drop_d;
      rvalid_q <= rvalid_d;
      rsel_q   <= rsel_d;
      rzero_q  <= rzero_d;
    end
  end

  assign rData      = rzero_q ? '0 : (rsel_q ? rd1 : rd0);
  assign rValid     = rvalid_q;
  assign frameReady = ready_q;
  assign wSkip      = wskip_q;
  assign dropCount  = drop_q;
  assign rBank      = rbank_q;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Self-checking bench for frame_buffer_pingpong: per-cycle model comparison plus directed literal checks.
module tb_frame_buffer_pingpong;

  localparam int unsigned DEPTH = 76800;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [16:0] wAddr = '0;
  logic [15:0] wData = '0;
  logic        wFrameEnd = 1'b0;
  logic        rFrameStart = 1'b0;
  logic        oe = 1'b0;
  logic [16:0] rAddr = '0;
  logic [15:0] rData;
  logic        rValid;
  logic        frameReady;
  logic        wSkip;
  logic [7:0]  dropCount;
  logic        rBank;

  int n_checks = 0;
  int n_fail   = 0;

  frame_buffer_pingpong dut (
    .clk         (clk),
    .reset       (reset),
    .we          (we),
    .wAddr       (wAddr),
    .wData       (wData),
    .wFrameEnd   (wFrameEnd),
    .rFrameStart (rFrameStart),
    .oe          (oe),
    .rAddr       (rAddr),
    .rData       (rData),
    .rValid      (rValid),
    .frameReady  (frameReady),
    .wSkip       (wSkip),
    .dropCount   (dropCount),
    .rBank       (rBank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two banks as a sparse map, pending-frame and mid-frame-discard flags.
  bit          m_started = 1'b0;
  bit          m_ready, m_tail, m_valid, m_known;
  int          m_front, m_back, m_drop;
  bit          m_discard;
  logic [15:0] m_rdata;
  logic [15:0] m_mem [int];

  function automatic int key(input int b, input logic [16:0] a);
    return b * 262144 + int'(a);
  endfunction

  task automatic m_drop_one();
    if (m_drop < 255) m_drop++;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_started = 1'b1;
      m_ready   = 1'b0;
      m_tail    = 1'b0;
      m_front   = 1;
      m_drop    = 0;
      m_valid   = 1'b0;
      m_rdata   = '0;
      m_known   = 1'b1;
    end else begin
      m_discard = m_ready || m_tail;
      m_back    = 1 - m_front;
      if (oe) begin
        m_valid = 1'b1;
        if (int'(rAddr) >= DEPTH) begin
          m_rdata = '0;
          m_known = 1'b1;
        end else if (m_mem.exists(key(m_front, rAddr))) begin
          m_rdata = m_mem[key(m_front, rAddr)];
          m_known = 1'b1;
        end else begin
          m_known = 1'b0;
        end
      end else begin
        m_valid = 1'b0;
      end
      if (we && !m_discard && int'(wAddr) < DEPTH) m_mem[key(m_back, wAddr)] = wData;
      if (!m_discard) begin
        if (wFrameEnd) begin
          if (rFrameStart) m_front = m_back;
          else m_ready = 1'b1;
        end
      end else if (m_ready) begin
        if (rFrameStart) begin
          m_front = m_back;
          m_ready = 1'b0;
          if (wFrameEnd) m_drop_one();
          else m_tail = 1'b1;
        end else if (wFrameEnd) begin
          m_drop_one();
        end
      end else if (wFrameEnd) begin
        m_drop_one();
        m_tail = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("model_rValid", 32'(rValid), 32'(m_valid));
      chk("model_rBank", 32'(rBank), 32'(m_front));
      chk("model_frameReady", 32'(frameReady), 32'(m_ready));
      chk("model_wSkip", 32'(wSkip), 32'(m_ready || m_tail));
      chk("model_dropCount", 32'(dropCount), 32'(m_drop));
      if (m_known) chk("model_rData", 32'(rData), 32'(m_rdata));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [16:0] a, input logic [15:0] d, input logic fe, input logic rfs);
    we = 1'b1; wAddr = a; wData = d; wFrameEnd = fe; rFrameStart = rfs;
    tick();
    we = 1'b0; wFrameEnd = 1'b0; rFrameStart = 1'b0;
  endtask

  task automatic rd(input logic [16:0] a);
    oe = 1'b1; rAddr = a;
    tick();
    oe = 1'b0;
  endtask

  task automatic pulse(input logic fe, input logic rfs);
    wFrameEnd = fe; rFrameStart = rfs;
    tick();
    wFrameEnd = 1'b0; rFrameStart = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then read from bank 1
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk("reset_rBank", 32'(rBank), 32'd1);
    chk("reset_frameReady", 32'(frameReady), 32'd0);
    chk("reset_dropCount", 32'(dropCount), 32'd0);
    chk("reset_wSkip", 32'(wSkip), 32'd0);
    chk("reset_rData", 32'(rData), 32'd0);
    rd(17'd0);
    chk("first_read_rValid", 32'(rValid), 32'd1);

    // Frame A into bank 0, data = address
    for (int i = 0; i < 32; i++) wr(17'(i), 16'(i), 1'b0, 1'b0);
    wr(17'd1234, 16'd1234, 1'b0, 1'b0);
    wr(17'd76799, 16'd11263, 1'b1, 1'b0);
    chk("fillA_frameReady", 32'(frameReady), 32'd1);
    chk("fillA_wSkip", 32'(wSkip), 32'd1);
    pulse(1'b0, 1'b1);
    chk("swapA_rBank", 32'(rBank), 32'd0);
    chk("swapA_frameReady", 32'(frameReady), 32'd0);
    chk("swapA_wSkip_skip", 32'(wSkip), 32'd1);
    rd(17'd1234);
    chk("readA_1234", 32'(rData), 32'd1234);
    rd(17'd76799);
    chk("readA_last", 32'(rData), 32'd11263);
    rd(17'd5);
    chk("readA_5", 32'(rData), 32'd5);
    tick();
    chk("idle_rValid", 32'(rValid), 32'd0);
    chk("idle_rData_hold", 32'(rData), 32'd5);
    pulse(1'b1, 1'b0);
    chk("skipA_drop", 32'(dropCount), 32'd1);
    chk("skipA_wSkip", 32'(wSkip), 32'd0);

    // Frame B into bank 1; last pixel, frame end, frame start and a read all on one cycle
    for (int i = 0; i < 32; i++) wr(17'(i), 16'h1000 + 16'(i), 1'b0, 1'b0);
    wr(17'd1234, 16'hB234, 1'b0, 1'b0);
    oe = 1'b1; rAddr = 17'd1234;
    wr(17'd76799, 16'hBEEF, 1'b1, 1'b1);
    oe = 1'b0;
    chk("simul_old_bank_read", 32'(rData), 32'd1234);
    chk("simul_rBank", 32'(rBank), 32'd1);
    chk("simul_wSkip", 32'(wSkip), 32'd0);
    chk("simul_frameReady", 32'(frameReady), 32'd0);
    rd(17'd1234);
    chk("readB_1234", 32'(rData), 32'hB234);
    rd(17'd76799);
    chk("readB_last", 32'(rData), 32'hBEEF);
    rd(17'd7);
    chk("readB_7", 32'(rData), 32'h1007);

    // Frame C into bank 0, then a dropped frame and discarded writes while held
    wr(17'd1234, 16'hC234, 1'b0, 1'b0);
    wr(17'd76799, 16'h0C0C, 1'b1, 1'b0);
    chk("fillC_frameReady", 32'(frameReady), 32'd1);
    pulse(1'b1, 1'b0);
    chk("hold_drop", 32'(dropCount), 32'd2);
    wr(17'd1234, 16'hFFFF, 1'b0, 1'b0);
    wr(17'd5, 16'hFFFF, 1'b0, 1'b0);
    pulse(1'b0, 1'b1);
    chk("swapC_rBank", 32'(rBank), 32'd0);
    chk("swapC_wSkip", 32'(wSkip), 32'd1);
    rd(17'd1234);
    chk("readC_1234", 32'(rData), 32'hC234);
    rd(17'd5);
    chk("readC_5_untouched", 32'(rData), 32'd5);
    pulse(1'b1, 1'b0);
    chk("skipC_drop", 32'(dropCount), 32'd3);
    chk("skipC_wSkip", 32'(wSkip), 32'd0);

    // Out-of-range writes and reads
    wr(17'd76800, 16'h5555, 1'b0, 1'b0);
    wr(17'h1FFFF, 16'h5555, 1'b0, 1'b0);
    wr(17'd1234, 16'hD234, 1'b0, 1'b0);
    rd(17'd76800);
    chk("oor_read_zero", 32'(rData), 32'd0);
    chk("oor_read_valid", 32'(rValid), 32'd1);
    wr(17'd0, 16'hD000, 1'b1, 1'b1);
    chk("swapD_rBank", 32'(rBank), 32'd1);
    rd(17'd1234);
    chk("readD_1234", 32'(rData), 32'hD234);
    rd(17'd0);
    chk("readD_0", 32'(rData), 32'hD000);

    // Held frame with end and start together
    wr(17'd0, 16'hE000, 1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    chk("hold_both_rBank", 32'(rBank), 32'd0);
    chk("hold_both_drop", 32'(dropCount), 32'd4);
    chk("hold_both_wSkip", 32'(wSkip), 32'd0);
    rd(17'd0);
    chk("readE_0", 32'(rData), 32'hE000);

    // Reset while a frame is held
    wr(17'd3, 16'h3333, 1'b1, 1'b0);
    chk("preReset_frameReady", 32'(frameReady), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midReset_frameReady", 32'(frameReady), 32'd0);
    chk("midReset_rBank", 32'(rBank), 32'd1);
    chk("midReset_wSkip", 32'(wSkip), 32'd0);
    chk("midReset_drop", 32'(dropCount), 32'd0);
    chk("midReset_rData", 32'(rData), 32'd0);
    wr(17'd9, 16'h0909, 1'b1, 1'b1);
    chk("postReset_rBank", 32'(rBank), 32'd0);
    rd(17'd9);
    chk("postReset_read", 32'(rData), 32'h0909);

    // Drop counter saturation
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 300; i++) begin
      pulse(1'b1, 1'b0);
      tick();
    end
    chk("sat_drop", 32'(dropCount), 32'd255);
    chk("sat_wSkip", 32'(wSkip), 32'd1);
    chk("sat_frameReady", 32'(frameReady), 32'd1);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
